// File: rtl/sd_cmd_rsp_if.sv
// Response request bus between the command decoder (master) and the CMD-line transmitter (slave).
// Handshake: a request is taken on a cycle where i_valid & o_ready & ~i_abort; the source holds its fields until then.
interface sd_cmd_rsp_if;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_type;
  logic [5:0]   i_index;
  logic [127:0] i_data;
  logic         i_abort;

  modport master (
    output i_valid, i_type, i_index, i_data, i_abort,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_type, i_index, i_data, i_abort,
    output o_ready
  );
endinterface

// File: rtl/sd_cmd_rsp_tx.sv
// Card-side SD CMD-line response transmitter: serialises R48/R3/R2 frames with CRC7,
// one bit per SD-clock falling-edge strobe, after an Ncr gap.
module sd_cmd_rsp_tx #(
  parameter int NCR_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sd_clk_fall,
  sd_cmd_rsp_if.slave        req,
  output logic               o_cmd,
  output logic               o_cmd_oe,
  output logic               o_done,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [135:0]   frame_q, frame_d;
  logic [6:0]     crc_q, crc_d;
  logic [7:0]     pos_q, pos_d;
  logic [7:0]     ncr_q, ncr_d;
  logic           is_r2_q, is_r2_d;
  logic           use_crc_q, use_crc_d;
  logic           cmd_q, cmd_d;
  logic           oe_q, oe_d;
  logic           done_q, done_d;

  logic           accept;
  logic           req_r2;
  logic           req_r3;
  logic [7:0]     present_pos;
  logic [7:0]     crc_idx;
  logic           pres_bit;
  logic           crc_cov;
  logic [6:0]     crc_next;

  assign req.o_ready  = (state_q == S_IDLE);
  assign accept       = req.i_valid & req.o_ready & ~req.i_abort;
  assign req_r2       = (req.i_type == 2'd2);
  assign req_r3       = (req.i_type == 2'd1);
  assign o_cmd        = cmd_q;
  assign o_cmd_oe     = oe_q;
  assign o_done       = done_q;
  assign o_dbg_state  = state_q;

  // Frame position of the bit presented on this strobe; the start bit comes from WAIT.
  always_comb begin
    present_pos = pos_q - 8'd1;
    if (state_q == S_WAIT) present_pos = is_r2_q ? 8'd135 : 8'd47;
    crc_idx  = present_pos - 8'd1;
    pres_bit = frame_q[135];
    if (use_crc_q && (present_pos >= 8'd1) && (present_pos <= 8'd7)) pres_bit = crc_q[crc_idx[2:0]];
    crc_cov  = (present_pos >= 8'd8) && (!is_r2_q || (present_pos <= 8'd127));
    crc_next = {crc_q[5:0], 1'b0} ^ ({7{pres_bit ^ crc_q[6]}} & 7'h09);
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    crc_d     = crc_q;
    pos_d     = pos_q;
    ncr_d     = ncr_q;
    is_r2_d   = is_r2_q;
    use_crc_d = use_crc_q;
    cmd_d     = cmd_q;
    oe_d      = oe_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // R3 carries all-ones index/CRC fields; R2 carries its CRC over the body only.
          if (req_r2) frame_d = {2'b00, 6'h3f, req.i_data[127:8], 8'h01};
          else        frame_d = {2'b00, (req_r3 ? 6'h3f : req.i_index), req.i_data[31:0],
                                 (req_r3 ? 7'h7f : 7'h00), 1'b1, 88'd0};
          crc_d     = 7'h00;
          ncr_d     = 8'd0;
          pos_d     = 8'd0;
          is_r2_d   = req_r2;
          use_crc_d = !req_r3;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_sd_clk_fall) begin
          if (ncr_q == 8'(NCR_CYCLES - 1)) begin
            state_d = S_SHIFT;
            cmd_d   = pres_bit;
            oe_d    = 1'b1;
            frame_d = {frame_q[134:0], 1'b0};
            pos_d   = present_pos;
            if (crc_cov) crc_d = crc_next;
          end else begin
            ncr_d = ncr_q + 8'd1;
          end
        end
      end
      S_SHIFT: begin
        if (i_sd_clk_fall) begin
          if (pos_q == 8'd0) begin
            state_d = S_IDLE;
            cmd_d   = 1'b1;
            oe_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cmd_d   = pres_bit;
            frame_d = {frame_q[134:0], 1'b0};
            pos_d   = present_pos;
            if (crc_cov) crc_d = crc_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort releases the line immediately and overrides any strobe in the same cycle.
    if (req.i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cmd_d   = 1'b1;
      oe_d    = 1'b0;
      done_d  = 1'b0;
      crc_d   = 7'h00;
      ncr_d   = 8'd0;
      pos_d   = 8'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      crc_q     <= 7'h00;
      pos_q     <= 8'd0;
      ncr_q     <= 8'd0;
      is_r2_q   <= 1'b0;
      use_crc_q <= 1'b0;
      cmd_q     <= 1'b1;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      crc_q     <= crc_d;
      pos_q     <= pos_d;
      ncr_q     <= ncr_d;
      is_r2_q   <= is_r2_d;
      use_crc_q <= use_crc_d;
      cmd_q     <= cmd_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_rsp_tx.sv
// Bench for sd_cmd_rsp_tx: known-frame table, randomized frames against a polynomial-division
// frame model, and hand-written abort/reset sequences.
module tb_sd_cmd_rsp_tx;
  localparam int NCR = 2;

  logic clk;
  logic rst;
  logic sd_fall;
  logic cmd;
  logic cmd_oe;
  logic done;
  logic [1:0] dbg_state;

  int n_chk;
  int n_fail;

  sd_cmd_rsp_if req_if ();

  sd_cmd_rsp_tx #(.NCR_CYCLES(NCR)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sd_clk_fall (sd_fall),
    .req           (req_if),
    .o_cmd         (cmd),
    .o_cmd_oe      (cmd_oe),
    .o_done        (done),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference frame: bit list built field by field, CRC7 as the remainder of M(x)*x^7 / (x^7+x^3+1).
  task automatic model(input logic [1:0] t, input logic [5:0] idx, input logic [127:0] d,
                       output logic [135:0] f, output int n);
    bit msg[$];
    bit r[$];
    int start;
    int m;
    msg.push_back(1'b0);
    msg.push_back(1'b0);
    if (t == 2'd2) begin
      for (int i = 0; i < 6; i++) msg.push_back(1'b1);
      for (int i = 127; i >= 8; i--) msg.push_back(d[i]);
      start = 8;
    end else begin
      for (int i = 5; i >= 0; i--) msg.push_back((t == 2'd1) ? 1'b1 : idx[i]);
      for (int i = 31; i >= 0; i--) msg.push_back(d[i]);
      start = 0;
    end
    m = msg.size() - start;
    for (int k = start; k < msg.size(); k++) r.push_back(msg[k]);
    for (int k = 0; k < 7; k++) r.push_back(1'b0);
    for (int i = 0; i < m; i++) begin
      if (r[i]) begin
        r[i]   = r[i] ^ 1'b1;
        r[i+4] = r[i+4] ^ 1'b1;
        r[i+7] = r[i+7] ^ 1'b1;
      end
    end
    for (int k = 0; k < 7; k++) msg.push_back((t == 2'd1) ? 1'b1 : r[m+k]);
    msg.push_back(1'b1);
    n = msg.size();
    f = '0;
    for (int k = 0; k < n; k++) f[135-k] = msg[k];
  endtask

  // ---------------- driver tasks ----------------
  task automatic strobe();
    @(negedge clk);
    sd_fall = 1'b1;
    @(posedge clk);
    #1;
    sd_fall = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] t, input logic [5:0] idx, input logic [127:0] d,
                          input logic stb_in_accept);
    @(negedge clk);
    chk("ready_before_accept", 136'(req_if.o_ready), 136'(1));
    req_if.i_valid = 1'b1;
    req_if.i_type  = t;
    req_if.i_index = idx;
    req_if.i_data  = d;
    sd_fall        = stb_in_accept;
    @(posedge clk);
    #1;
    sd_fall        = 1'b0;
    req_if.i_valid = 1'b0;
    chk("ready_after_accept", 136'(req_if.o_ready), 136'(0));
  endtask

  // Strobes the full frame, capturing o_cmd after each strobe, then checks the release strobe.
  task automatic run_frame(input string nm, input logic [135:0] exp, input int n);
    logic [135:0] got;
    logic oe_pre_ok;
    logic oe_ok;
    logic hold_ok;
    logic last;
    int gap;
    got       = '0;
    oe_pre_ok = 1'b1;
    oe_ok     = 1'b1;
    hold_ok   = 1'b1;
    for (int i = 0; i < NCR - 1; i++) begin
      strobe();
      if (cmd_oe !== 1'b0) oe_pre_ok = 1'b0;
    end
    for (int b = 0; b < n; b++) begin
      strobe();
      got[135-b] = cmd;
      last = cmd;
      if (cmd_oe !== 1'b1) oe_ok = 1'b0;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        if (cmd !== last || cmd_oe !== 1'b1 || done !== 1'b0) hold_ok = 1'b0;
      end
    end
    chk({nm, "_oe_during_ncr"}, 136'(oe_pre_ok), 136'(1));
    chk({nm, "_frame"}, got, exp);
    chk({nm, "_oe_during_frame"}, 136'(oe_ok), 136'(1));
    chk({nm, "_hold_between_strobes"}, 136'(hold_ok), 136'(1));
    strobe();
    chk({nm, "_release_oe_cmd_done_ready"}, 136'({cmd_oe, cmd, done, req_if.o_ready}), 136'(4'b0111));
    @(posedge clk);
    #1;
    chk({nm, "_done_one_cycle"}, 136'(done), 136'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        nm;
    logic [1:0]   t;
    logic [5:0]   idx;
    logic [127:0] data;
    logic [135:0] exp;
    int           n;
    logic         stb_acc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [135:0] e;
    int n;
    logic [1:0] t;
    logic [5:0] idx;
    logic [127:0] d;

    n_chk  = 0;
    n_fail = 0;
    rst            = 1'b1;
    sd_fall        = 1'b0;
    req_if.i_valid = 1'b0;
    req_if.i_type  = 2'd0;
    req_if.i_index = 6'd0;
    req_if.i_data  = '0;
    req_if.i_abort = 1'b0;

    tbl[0] = '{"r7", 2'd0, 6'd8, 128'h1AA, {48'h08000001AA13, 88'd0}, 48, 1'b1};
    tbl[1] = '{"r1", 2'd0, 6'd55, 128'h120, {48'h370000012083, 88'd0}, 48, 1'b0};
    tbl[2] = '{"r3", 2'd1, 6'h15, 128'h80FF8000, {48'h3F80FF8000FF, 88'd0}, 48, 1'b1};
    tbl[3] = '{"r2_cid", 2'd2, 6'd2, 128'h03_5344_5355_3136_4780_1234_5678_0147_5A, '0, 136, 1'b0};
    tbl[4] = '{"reserved_type", 2'd3, 6'd17, 128'hDEADBEEF, '0, 48, 1'b0};
    model(tbl[3].t, tbl[3].idx, tbl[3].data, tbl[3].exp, n);
    model(tbl[4].t, tbl[4].idx, tbl[4].data, tbl[4].exp, n);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", 136'(req_if.o_ready), 136'(1));
    chk("reset_oe", 136'(cmd_oe), 136'(0));
    chk("reset_cmd", 136'(cmd), 136'(1));
    chk("reset_done", 136'(done), 136'(0));

    // Table of known frames
    for (int v = 0; v < 5; v++) begin
      send_req(tbl[v].t, tbl[v].idx, tbl[v].data, tbl[v].stb_acc);
      run_frame(tbl[v].nm, tbl[v].exp, tbl[v].n);
    end

    // Randomized frames against the model
    for (int r = 0; r < 6; r++) begin
      t   = 2'($urandom_range(0, 3));
      idx = 6'($urandom_range(0, 63));
      d   = {$urandom, $urandom, $urandom, $urandom};
      model(t, idx, d, e, n);
      send_req(t, idx, d, 1'($urandom_range(0, 1)));
      run_frame("rand", e, n);
    end

    // Abort in IDLE beats a simultaneous request
    @(negedge clk);
    req_if.i_valid = 1'b1;
    req_if.i_abort = 1'b1;
    req_if.i_type  = 2'd0;
    @(posedge clk);
    #1;
    req_if.i_valid = 1'b0;
    req_if.i_abort = 1'b0;
    chk("abort_blocks_accept_ready", 136'(req_if.o_ready), 136'(1));
    begin
      logic quiet;
      quiet = 1'b1;
      for (int i = 0; i < NCR + 3; i++) begin
        strobe();
        if (cmd_oe !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      end
      chk("abort_blocks_accept_line_quiet", 136'(quiet), 136'(1));
    end

    // Abort at bit 20 of an R2 frame, together with a strobe
    send_req(2'd2, 6'd0, tbl[3].data, 1'b0);
    for (int i = 0; i < NCR - 1 + 20; i++) strobe();
    chk("abort_pre_oe", 136'(cmd_oe), 136'(1));
    @(negedge clk);
    sd_fall        = 1'b1;
    req_if.i_abort = 1'b1;
    @(posedge clk);
    #1;
    sd_fall        = 1'b0;
    req_if.i_abort = 1'b0;
    chk("abort_release", 136'({cmd_oe, cmd, req_if.o_ready, done}), 136'(4'b0110));
    chk("abort_state_idle", 136'(dbg_state), 136'(0));
    begin
      logic quiet;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
        strobe();
        if (cmd_oe !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      end
      chk("abort_no_done", 136'(quiet), 136'(1));
    end
    send_req(tbl[0].t, tbl[0].idx, tbl[0].data, 1'b0);
    run_frame("r7_after_abort", tbl[0].exp, 48);

    // Reset at bit 100 of an R2 frame
    send_req(2'd2, 6'd0, tbl[3].data, 1'b0);
    for (int i = 0; i < NCR - 1 + 100; i++) strobe();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_mid_release", 136'({cmd_oe, cmd, req_if.o_ready, done}), 136'(4'b0110));
    send_req(tbl[0].t, tbl[0].idx, tbl[0].data, 1'b1);
    run_frame("r7_after_reset", tbl[0].exp, 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
